// File: rtl/audio_pkg.sv
// Shared types and sample arithmetic for the I2S audio transmitter.
// Volume scaling and mono mixing are pure functions used at frame load.
package audio_pkg;

    localparam int I2S_BITS = 32;

    typedef logic signed [15:0] sample_t;

    function automatic sample_t vol_scale(input sample_t s, input logic [1:0] v);
        sample_t r;
        unique case (v)
            2'd0: r = '0;
            2'd1: r = s >>> 2;
            2'd2: r = s >>> 1;
            2'd3: r = s;
        endcase
        return r;
    endfunction

    function automatic sample_t sat_mix(input sample_t a, input sample_t b);
        logic signed [16:0] sum;
        logic signed [16:0] half;
        sample_t r;
        sum  = {a[15], a} + {b[15], b};
        half = sum >>> 1;
        if (half > 17'sd32767)
            r = 16'sh7fff;
        else if (half < -17'sd32768)
            r = 16'sh8000;
        else
            r = half[15:0];
        return r;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Fractional-accumulator bit clock generator; exact average BCK rate
// for either core clock, with a registered bck and edge-tick strobes.
module i2s_bclk_gen #(
    parameter int CLK_HZ_PAL  = 31520000,
    parameter int CLK_HZ_NTSC = 32940000,
    parameter int SAMPLE_RATE = 48000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ntscmode,
    output logic bck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int STEP = 64 * SAMPLE_RATE;
    localparam int AW   = $clog2(CLK_HZ_NTSC + STEP) + 1;

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [AW-1:0] limit;
    logic          tick;

    assign limit     = ntscmode ? AW'(CLK_HZ_NTSC) : AW'(CLK_HZ_PAL);
    assign sum       = acc + AW'(STEP);
    assign tick      = (sum >= limit);
    assign rise_tick = tick & ~bck;
    assign fall_tick = tick & bck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            bck <= 1'b0;
        end else begin
            acc <= tick ? (sum - limit) : sum;
            bck <= bck ^ tick;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S serializer: one-pair holding buffer, volume/mono at frame load,
// standard I2S framing (MSB one BCK after the ws edge).
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int   CLK_HZ_PAL  = 31520000,
    parameter int   CLK_HZ_NTSC = 32940000,
    parameter int   SAMPLE_RATE = 48000,
    parameter logic STEREO      = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ntscmode,
    input  logic [1:0]  system_volume,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din,
    output logic        underrun,
    output logic        underrun_sticky
);

    localparam int CW = $clog2(I2S_BITS);

    logic          fall_tick;
    logic          rise_unused;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] k_next;
    logic [CW-1:0] din_idx;
    logic [31:0]   frame;
    sample_t       hl;
    sample_t       hr;
    logic          hold_full;
    logic          load;
    logic          starve;
    logic          capture;

    i2s_bclk_gen #(
        .CLK_HZ_PAL  (CLK_HZ_PAL),
        .CLK_HZ_NTSC (CLK_HZ_NTSC),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_bclk (
        .clk       (clk),
        .reset_n   (reset_n),
        .ntscmode  (ntscmode),
        .bck       (hp_bck),
        .rise_tick (rise_unused),
        .fall_tick (fall_tick)
    );

    function automatic logic [31:0] pack_frame(
        input sample_t l, input sample_t r, input logic [1:0] v
    );
        sample_t m;
        m = sat_mix(l, r);
        if (STEREO)
            return {vol_scale(l, v), vol_scale(r, v)};
        return {vol_scale(m, v), vol_scale(m, v)};
    endfunction

    // 32-k mod 32 also yields index 0 (previous R LSB) for k=0
    assign k_next       = bit_cnt + CW'(1);
    assign din_idx      = CW'(0) - k_next;
    assign load         = fall_tick && (k_next == '0);
    assign starve       = load && !hold_full && !sample_valid;
    assign capture      = sample_valid && !hold_full && !load;
    assign sample_ready = !hold_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt         <= '1;
            hp_ws           <= 1'b0;
            hp_din          <= 1'b0;
            frame           <= '0;
            hl              <= '0;
            hr              <= '0;
            hold_full       <= 1'b0;
            underrun        <= 1'b0;
            underrun_sticky <= 1'b0;
        end else begin
            underrun <= starve;
            if (starve)
                underrun_sticky <= 1'b1;
            if (fall_tick) begin
                bit_cnt <= k_next;
                hp_ws   <= (k_next >= CW'(I2S_BITS / 2));
                hp_din  <= frame[din_idx];
            end
            if (load && hold_full) begin
                frame     <= pack_frame(hl, hr, system_volume);
                hold_full <= 1'b0;
            end else if (load && sample_valid) begin
                frame <= pack_frame(sample_l, sample_r, system_volume);
            end
            if (capture) begin
                hl        <= sample_l;
                hr        <= sample_r;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: I2S receiver model, divider rate model,
// table-driven sample/volume/mono vectors and handshake corner cases.
module tb_audio_i2s_tx;

    localparam int PAL  = 31520000;
    localparam int NTSC = 32940000;
    localparam int SR   = 48000;
    localparam int STEP = 64 * SR;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [1:0]  v;
        logic [31:0] est;
        logic [31:0] emo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ntscmode = 1'b0;
    logic [1:0]  system_volume = 2'd3;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic [1:0]  rdy, bck, ws, din, ur, urs;

    audio_i2s_tx #(.CLK_HZ_PAL(PAL), .CLK_HZ_NTSC(NTSC),
                   .SAMPLE_RATE(SR), .STEREO(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .ntscmode(ntscmode),
        .system_volume(system_volume), .sample_l(sample_l),
        .sample_r(sample_r), .sample_valid(sample_valid),
        .sample_ready(rdy[0]), .hp_bck(bck[0]), .hp_ws(ws[0]),
        .hp_din(din[0]), .underrun(ur[0]), .underrun_sticky(urs[0]));

    audio_i2s_tx #(.CLK_HZ_PAL(PAL), .CLK_HZ_NTSC(NTSC),
                   .SAMPLE_RATE(SR), .STEREO(1'b0)) dut_m (
        .clk(clk), .reset_n(reset_n), .ntscmode(ntscmode),
        .system_volume(system_volume), .sample_l(sample_l),
        .sample_r(sample_r), .sample_valid(sample_valid),
        .sample_ready(rdy[1]), .hp_bck(bck[1]), .hp_ws(ws[1]),
        .hp_din(din[1]), .underrun(ur[1]), .underrun_sticky(urs[1]));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int fdiv(input int x, input int d);
        int q;
        q = x / d;
        if ((x % d) != 0 && x < 0) q--;
        return q;
    endfunction

    function automatic int s16(input logic [15:0] a);
        return int'($signed(a));
    endfunction

    function automatic logic [15:0] ref_vol(input int x, input logic [1:0] v);
        case (v)
            2'd0: return 16'h0000;
            2'd1: return 16'(fdiv(x, 4));
            2'd2: return 16'(fdiv(x, 2));
            default: return 16'(x);
        endcase
    endfunction

    function automatic logic [15:0] ref_mono(input logic [15:0] l,
                                             input logic [15:0] r,
                                             input logic [1:0] v);
        int m;
        m = fdiv(s16(l) + s16(r), 2);
        if (m > 32767) m = 32767;
        if (m < -32768) m = -32768;
        return ref_vol(m, v);
    endfunction

    // receiver / counters, sampled 1 time unit after each rising clk
    int          ncyc, tog, ur_cnt, din_ones, last_tog;
    bit          have_tog;
    logic        pb[2], pws[2];
    logic [31:0] sr[2], rx_frame[2];
    int          rx_cnt[2] = '{0, 0};
    int          rises[2], since_edge[2], first_ws1[2];
    bit          have_edge[2];

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            ncyc = 0; tog = 0; ur_cnt = 0; din_ones = 0; have_tog = 0;
            for (int i = 0; i < 2; i++) begin
                pb[i] = 1'b0; pws[i] = 1'b0; rises[i] = 0;
                since_edge[i] = 0; have_edge[i] = 0; first_ws1[i] = 0;
            end
        end else begin
            ncyc++;
            if (bck[0] != pb[0]) begin
                tog++;
                if (have_tog)
                    chk("bck_width", 32'(ncyc - last_tog >= 8), 32'd1);
                have_tog = 1;
                last_tog = ncyc;
            end
            if (ur[0]) ur_cnt++;
            if (din[0]) din_ones++;
            for (int i = 0; i < 2; i++) begin
                if (bck[i] && !pb[i]) begin
                    rises[i]++;
                    since_edge[i]++;
                    sr[i] = {sr[i][30:0], din[i]};
                    if (ws[i] && first_ws1[i] == 0) first_ws1[i] = rises[i];
                    if (ws[i] != pws[i]) begin
                        if (have_edge[i]) chk("ws_half", since_edge[i], 16);
                        have_edge[i] = 1;
                        since_edge[i] = 0;
                        if (!ws[i]) begin
                            rx_frame[i] = sr[i];
                            rx_cnt[i]++;
                        end
                    end
                    pws[i] = ws[i];
                end
                pb[i] = bck[i];
            end
        end
    end

    task automatic wait_frames(input int n);
        int target;
        target = rx_cnt[0] + n;
        for (int c = 0; c < n * 800 + 1000 && rx_cnt[0] < target; c++)
            @(negedge clk);
        if (rx_cnt[0] < target) chk("frame_timeout", rx_cnt[0], target);
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 2000 && !rdy[0]; c++) @(negedge clk);
        if (!rdy[0]) chk("ready_timeout", rdy[0], 1);
    endtask

    vec_t tbl[12];

    initial begin
        int ur0, c, m, t, d;
        longint n;
        logic [15:0] bm;

        tbl[0] = '{16'h8001, 16'h7ffe, 2'd3, 32'h80017ffe, 32'hffffffff};
        tbl[1] = '{16'hf000, 16'hf000, 2'd1, 32'hfc00fc00, 32'hfc00fc00};
        tbl[2] = '{16'hf000, 16'hf000, 2'd2, 32'hf800f800, 32'hf800f800};
        tbl[3] = '{16'hf000, 16'hf000, 2'd0, 32'h00000000, 32'h00000000};
        tbl[4] = '{16'h7fff, 16'h7fff, 2'd3, 32'h7fff7fff, 32'h7fff7fff};
        tbl[5] = '{16'h8000, 16'h7fff, 2'd3, 32'h80007fff, 32'hffffffff};
        tbl[6] = '{16'h8000, 16'h8000, 2'd3, 32'h80008000, 32'h80008000};
        tbl[7] = '{16'hffff, 16'h0001, 2'd1, 32'hffff0000, 32'h00000000};
        for (int i = 8; i < 12; i++) begin
            tbl[i].l = 16'($urandom);
            tbl[i].r = 16'($urandom);
            tbl[i].v = 2'($urandom_range(0, 3));
            tbl[i].est = {ref_vol(s16(tbl[i].l), tbl[i].v),
                          ref_vol(s16(tbl[i].r), tbl[i].v)};
            bm = ref_mono(tbl[i].l, tbl[i].r, tbl[i].v);
            tbl[i].emo = {bm, bm};
        end

        repeat (3) @(negedge clk);
        chk("rst_bck", bck[0], 0);
        chk("rst_ws", ws[0], 0);
        chk("rst_din", din[0], 0);
        chk("rst_ready", rdy[0], 1);
        chk("rst_underrun", ur[0], 0);
        chk("rst_sticky", urs[0], 0);
        reset_n = 1'b1;

        // idle stream: exact divider rate, one underrun per frame
        repeat (15000) @(negedge clk);
        chk("pal_rate", tog, int'((longint'(ncyc) * STEP) / PAL));
        chk("idle_underruns", ur_cnt, ((tog / 2) + 31) / 32);
        chk("idle_din", din_ones, 0);
        chk("idle_sticky", urs[0], 1);
        chk("first_ws_rise", first_ws1[0], 18);

        // table vectors, producer keeps valid high throughout
        ur0 = ur_cnt;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) wait_ready();
            sample_l = tbl[i].l;
            sample_r = tbl[i].r;
            system_volume = tbl[i].v;
            sample_valid = 1'b1;
            wait_frames(4);
            chk($sformatf("row%0d_stereo", i), rx_frame[0], tbl[i].est);
            chk($sformatf("row%0d_mono", i), rx_frame[1], tbl[i].emo);
        end
        chk("stream_underruns", ur_cnt - ur0, 0);

        wait_ready();
        @(negedge clk);
        chk("ready_pulse", rdy[0], 0);
        c = 1;
        while (!rdy[0] && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("ready_period", 32'(c >= 655 && c <= 658), 32'd1);

        // bypass: valid only in the k=0 cycle with an empty buffer
        sample_valid = 1'b0;
        sample_l = 16'h1234;
        sample_r = 16'habcd;
        system_volume = 2'd3;
        wait_frames(2);
        m = tog / 64 + 1;
        t = 2 + 64 * m;
        n = (longint'(t) * PAL + STEP - 1) / STEP;
        while (n <= ncyc + 1) begin
            m++;
            t = 2 + 64 * m;
            n = (longint'(t) * PAL + STEP - 1) / STEP;
        end
        for (int k = 0; k < 2000 && ncyc < n - 1; k++) @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("bypass_edge", 32'(ncyc), 32'(n));
        chk("bypass_underrun", ur[0], 0);
        chk("bypass_ready", rdy[0], 1);
        wait_frames(2);
        chk("bypass_frame", rx_frame[0], 32'h1234abcd);
        bm = ref_mono(16'h1234, 16'habcd, 2'd3);
        chk("bypass_mono", rx_frame[1], {bm, bm});

        // asynchronous reset mid-word
        sample_l = 16'h8001;
        sample_r = 16'h7ffe;
        sample_valid = 1'b1;
        wait_frames(3);
        for (int k = 0; k < 2000 && !(ws[0] && din[0]); k++) @(negedge clk);
        chk("pre_reset_ws", ws[0], 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_bck", bck[0], 0);
        chk("async_ws", ws[0], 0);
        chk("async_din", din[0], 0);
        chk("async_sticky", urs[0], 0);
        chk("async_ready", rdy[0], 1);
        sample_valid = 1'b0;
        ntscmode = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        repeat (8000) @(negedge clk);
        chk("ntsc_rate", tog, int'((longint'(ncyc) * STEP) / NTSC));
        chk("reset_first_k0", first_ws1[0], 18);

        // ntscmode toggling mid-frame, then steady-state rate
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(40, 600)) @(negedge clk);
            ntscmode = ~ntscmode;
        end
        repeat (200) @(negedge clk);
        t = tog;
        repeat (8000) @(negedge clk);
        d = (tog - t) - int'((longint'(8000) * STEP) / NTSC);
        chk("ntsc_converge", 32'(d >= -2 && d <= 2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Standalone I2S serializer for the SID audio path. It replaces the inline bit-clock and shift logic in the LCD video/audio stage and drives the board headphone DAC and amplifier (hp_bck/hp_ws/hp_din).
- Accepts signed 16-bit L/R samples over a valid/ready handshake and buffers one sample pair.
- Applies OSD volume and optional mono mix.
- Generates the bit clock from the core clock with a fractional accumulator, so the PAL and NTSC core clocks both give an exact average rate.

Parameters:
- CLK_HZ_PAL, 31520000, core clock frequency in Hz when ntscmode=0.
- CLK_HZ_NTSC, 32940000, core clock frequency in Hz when ntscmode=1.
- SAMPLE_RATE, 48000, output frame rate in Hz. BCK = 32*SAMPLE_RATE.
- STEREO, 1'b0, 1 = independent channels; 0 = both channels carry the mono mix.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- ntscmode  in  1  selects the CLK_HZ_* constant; sampled every cycle.
- system_volume  in  2  0 = mute, 1 = x1/4, 2 = x1/2, 3 = x1 (arithmetic shift).
- sample_l  in  16  signed left sample.
- sample_r  in  16  signed right sample.
- sample_valid  in  1  the sample pair is valid.
- sample_ready  out  1  holding buffer is empty (= !hold_full).
- hp_bck  out  1  I2S bit clock, registered.
- hp_ws  out  1  word select; 0 = left, 1 = right.
- hp_din  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse when a frame starts with no new sample.
- underrun_sticky  out  1  set on any underrun; cleared only by reset.

Behaviour:

Reset (asynchronous):
- acc=0, bck=0, ws=0, din=0, bit_cnt=31, frame=0, hold_full=0.
- sample_ready=1; underrun=0; underrun_sticky=0.

Divider (every cycle):
- limit = ntscmode ? CLK_HZ_NTSC : CLK_HZ_PAL; STEP = 64*SAMPLE_RATE.
- If acc+STEP >= limit: acc <= acc+STEP-limit, bck toggles (tick). Otherwise acc <= acc+STEP.
- Accumulator width: ceil(log2(CLK_HZ_NTSC+STEP))+1.
- A mid-stream ntscmode change is legal. acc is kept, at most one subtract per cycle, and the stream self-recovers within 2 ticks. No glitch pulse shorter than 1 clk is allowed.

Falling event (tick while bck=1):
- bit_cnt <= bit_cnt+1 (wraps mod 32).
- ws <= (new bit_cnt >= 16).
- din for new k=bit_cnt:
  - k=0: din <= frame[0] (previous right LSB), using the old frame before reload.
  - k=1..31: din <= frame[32-k]. k=1 gives L MSB (frame[31]); k=17 gives R MSB.
- This is standard I2S: MSB one BCK after the ws edge. The receiver samples on the rising bck.

Frame load (at the k=0 event):
- If hold_full: frame <= {vol(hl), vol(hr)}; hold_full <= 0.
- Else if sample_valid in the same cycle: frame loads directly from the inputs (bypass). The handshake completes and there is no underrun.
- Else: frame is kept (last sample repeated); underrun=1 for one cycle; sticky set.

Capture:
- On sample_valid && sample_ready outside the bypass case: hl/hr <= inputs and hold_full <= 1.
- Valid held while not ready: no effect. The producer must hold data stable.

Mono mix (STEREO=0):
- m = sat16((L+R)>>>1) using a 17-bit sum; the shift makes saturation a no-op but it is kept for safety.
- Both halves of the frame = vol(m).

Volume:
- vol() is applied at frame load using the current system_volume value.
- Mute forces 16'h0000, never -0 or a truncated negative.

Latency:
- A sample accepted just before a k=0 event appears as the L MSB on hp_din at the next falling event (~1 BCK).
- Worst case is 1 frame + 1 BCK.

Other boundary conditions:
- Reset mid-frame: outputs go to reset values immediately; the first falling event after release has k=0.
- A tick and a capture in the same cycle are both honoured.

Decomposition:
- Package audio_pkg holds:
  - constant I2S_BITS=32;
  - typedef sample_t (logic signed [15:0]);
  - function vol_scale(sample_t, logic[1:0]);
  - function sat_mix(sample_t, sample_t).
- One sub-module, i2s_bclk_gen: the fractional accumulator plus bck register. Outputs bck, rise_tick and fall_tick; inputs are ntscmode and the two CLK_HZ parameters.

Test Plan:
- Reset release, no samples, ntscmode=0, STEREO=1:
  - 48000 frames per 31520000 clk (±1 frame over 1 s);
  - ws period = 32 BCK; hp_din=0;
  - underrun pulses once per frame; underrun_sticky=1 after the first frame.
- Feed L=16'h8001, R=16'h7FFE, volume=3, STEREO=1:
  - serial capture on rising bck decodes L=8001, R=7FFE;
  - L MSB appears 1 BCK after ws falls.
- Volume sweep with L=16'hF000: vol 1 gives F C00, vol 2 gives F800, vol 0 gives 0000.
- STEREO=0, L=16'h7FFF, R=16'h7FFF: both channels = 7FFF. L=16'h8000, R=16'h7FFF: both channels = FFFF.
- Producer holds valid continuously: sample_ready deasserts after a capture and reasserts the cycle after each k=0 event; zero underruns over 1000 frames. Assert sample_valid exactly on a k=0 cycle with the buffer empty: bypass load, no underrun.
- Toggle ntscmode mid-frame: no bck pulse shorter than 1 clk; average rate converges to 32940000/(64*48000) clk per toggle. Assert reset_n low mid-word: hp_bck, hp_ws and hp_din go to 0 asynchronously.
